// File: rtl/spm_mem_responder.sv
// Fixed-latency, in-order cache-line read responder backed by a preloadable line array.
// Optional address range check enabled by defining SPM_RESP_RANGE_CHK_EN.
module spm_mem_responder #(
    parameter int unsigned LINE_W      = 512,
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned LAT         = 4,
    parameter int unsigned QDEPTH      = 8,
    parameter int unsigned TID_W       = 6,
    localparam int unsigned IDX_W      = $clog2(DEPTH_LINES),
    localparam int unsigned CNT_W      = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_val,
    output logic              mem_req_rdy,
    input  logic [TID_W-1:0]  mem_req_transid,
    input  logic [39:0]       mem_req_addr,
    output logic              mem_resp_val,
    output logic [TID_W-1:0]  mem_resp_transid,
    output logic [LINE_W-1:0] mem_resp_data,
`ifdef SPM_RESP_RANGE_CHK_EN
    output logic              mem_resp_err,
`endif
    input  logic              ld_val,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [LINE_W-1:0] ld_data,
    output logic [CNT_W-1:0]  inflight_cnt,
    output logic              err_dup_tid
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned AGE_W = $clog2(LAT) + 1;
    localparam int unsigned OFS_W = 6;

    logic [LINE_W-1:0] r_mem [DEPTH_LINES];

    logic [TID_W-1:0]  r_tid  [QDEPTH];
    logic [LINE_W-1:0] r_data [QDEPTH];
    logic [AGE_W-1:0]  r_age  [QDEPTH];
    logic [QDEPTH-1:0] r_vld;
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_resp_val;
    logic [TID_W-1:0]  r_resp_tid;
    logic [LINE_W-1:0] r_resp_data;
    logic              r_err_dup;

    logic              w_acc;
    logic              w_pop;
    logic              w_dup;
    logic [IDX_W-1:0]  w_idx;
    logic [LINE_W-1:0] w_line;
    logic [PTR_W-1:0]  w_wp_nxt;
    logic [PTR_W-1:0]  w_rp_nxt;

`ifdef SPM_RESP_RANGE_CHK_EN
    logic              r_err_q [QDEPTH];
    logic              r_resp_err;
    logic              w_oor;

    assign w_oor  = |mem_req_addr[39:OFS_W+IDX_W];
    assign w_line = w_oor ? '0 : r_mem[w_idx];
`else
    logic              w_unused_addr;

    // Byte offset and upper address bits are don't-care; the index aliases.
    assign w_unused_addr = ^{mem_req_addr[OFS_W-1:0], mem_req_addr[39:OFS_W+IDX_W]};
    assign w_line        = r_mem[w_idx];
`endif

    assign w_idx       = mem_req_addr[OFS_W +: IDX_W];
    assign mem_req_rdy = (r_cnt < CNT_W'(QDEPTH));
    assign w_acc       = mem_req_val & mem_req_rdy;
    assign w_pop       = r_vld[r_rp] && (r_age[r_rp] == AGE_W'(LAT - 1));
    assign w_wp_nxt    = (r_wp == PTR_W'(QDEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
    assign w_rp_nxt    = (r_rp == PTR_W'(QDEPTH - 1)) ? '0 : r_rp + PTR_W'(1);

    // Duplicate-id detection across all live entries
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < int'(QDEPTH); i++) begin
            if (r_vld[i] && (r_tid[i] == mem_req_transid)) begin
                w_dup = 1'b1;
            end
        end
    end

    // Backing array: preload port, not cleared by reset
    always_ff @(posedge clk) begin
        if (ld_val) begin
            r_mem[ld_idx] <= ld_data;
        end
    end

    // In-flight payload and age; meaningful only where r_vld is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(QDEPTH); i++) begin
            if (r_vld[i]) begin
                r_age[i] <= r_age[i] + AGE_W'(1);
            end
        end
        if (w_acc) begin
            r_tid[r_wp]  <= mem_req_transid;
            r_data[r_wp] <= w_line;
            r_age[r_wp]  <= '0;
`ifdef SPM_RESP_RANGE_CHK_EN
            r_err_q[r_wp] <= w_oor;
`endif
        end
    end

    // Queue control, counters and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_resp_val  <= 1'b0;
            r_resp_tid  <= '0;
            r_resp_data <= '0;
            r_err_dup   <= 1'b0;
`ifdef SPM_RESP_RANGE_CHK_EN
            r_resp_err  <= 1'b0;
`endif
        end else begin
            if (w_acc) begin
                r_vld[r_wp] <= 1'b1;
                r_wp        <= w_wp_nxt;
            end
            if (w_pop) begin
                r_vld[r_rp] <= 1'b0;
                r_rp        <= w_rp_nxt;
                r_resp_tid  <= r_tid[r_rp];
                r_resp_data <= r_data[r_rp];
`ifdef SPM_RESP_RANGE_CHK_EN
                r_resp_err  <= r_err_q[r_rp];
`endif
            end
            r_resp_val <= w_pop;
            if (w_acc && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_acc && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_acc && w_dup) begin
                r_err_dup <= 1'b1;
            end
        end
    end

    assign mem_resp_val     = r_resp_val;
    assign mem_resp_transid = r_resp_tid;
    assign mem_resp_data    = r_resp_data;
    assign inflight_cnt     = r_cnt;
    assign err_dup_tid      = r_err_dup;
`ifdef SPM_RESP_RANGE_CHK_EN
    assign mem_resp_err     = r_resp_err;
`endif

endmodule

// File: tb/tb_spm_mem_responder.sv
// Scoreboard bench for spm_mem_responder: main instance (QDEPTH=8) and a shallow one (QDEPTH=4).
module tb_spm_mem_responder;

    localparam int unsigned LW  = 512;
    localparam int unsigned LAT = 4;

    typedef struct {
        logic [5:0]    tid;
        logic [LW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_val = 1'b0;
    logic [7:0]    ld_idx = '0;
    logic [LW-1:0] ld_data = '0;

    logic          v0 = 1'b0, v1 = 1'b0;
    logic [5:0]    tid0 = '0, tid1 = '0;
    logic [39:0]   addr0 = '0, addr1 = '0;
    logic          rdy0, rdy1, rv0, rv1, dup0, dup1;
    logic [5:0]    rt0, rt1;
    logic [LW-1:0] rd0, rd1;
    logic [3:0]    cnt0;
    logic [2:0]    cnt1;
    logic          re0, re1;

    logic [LW-1:0] model [256];
    exp_t          q0[$];
    exp_t          q1[$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_bad = 0;

    spm_mem_responder #(.LINE_W(LW), .DEPTH_LINES(256), .LAT(LAT), .QDEPTH(8), .TID_W(6)) u0 (
        .clk(clk), .rst(rst), .mem_req_val(v0), .mem_req_rdy(rdy0),
        .mem_req_transid(tid0), .mem_req_addr(addr0), .mem_resp_val(rv0),
        .mem_resp_transid(rt0), .mem_resp_data(rd0),
`ifdef SPM_RESP_RANGE_CHK_EN
        .mem_resp_err(re0),
`endif
        .ld_val(ld_val), .ld_idx(ld_idx), .ld_data(ld_data),
        .inflight_cnt(cnt0), .err_dup_tid(dup0)
    );

    spm_mem_responder #(.LINE_W(LW), .DEPTH_LINES(256), .LAT(LAT), .QDEPTH(4), .TID_W(6)) u1 (
        .clk(clk), .rst(rst), .mem_req_val(v1), .mem_req_rdy(rdy1),
        .mem_req_transid(tid1), .mem_req_addr(addr1), .mem_resp_val(rv1),
        .mem_resp_transid(rt1), .mem_resp_data(rd1),
`ifdef SPM_RESP_RANGE_CHK_EN
        .mem_resp_err(re1),
`endif
        .ld_val(ld_val), .ld_idx(ld_idx), .ld_data(ld_data),
        .inflight_cnt(cnt1), .err_dup_tid(dup1)
    );

`ifndef SPM_RESP_RANGE_CHK_EN
    assign re0 = 1'b0;
    assign re1 = 1'b0;
`endif

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic exp_t exp_of(input logic [5:0] tid, input logic [39:0] addr);
        exp_t e;
        e.tid = tid;
        e.cyc = cyc + 1 + int'(LAT);
        e.err = 1'b0;
        e.data = model[addr[13:6]];
`ifdef SPM_RESP_RANGE_CHK_EN
        if (addr[39:14] != '0) begin
            e.err = 1'b1;
            e.data = '0;
        end
`endif
        return e;
    endfunction

    // Main-instance driver: one cycle per call, scoreboard push on accept
    task automatic step0(input logic v, input logic [5:0] tid, input logic [39:0] addr,
                         input logic lv, input logic [7:0] li, input logic [LW-1:0] ld);
        v0 = v; tid0 = tid; addr0 = addr;
        ld_val = lv; ld_idx = li; ld_data = ld;
        if (v && rdy0) q0.push_back(exp_of(tid, addr));
        if (lv) model[li] = ld;
        @(negedge clk);
        v0 = 1'b0; ld_val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    // Response monitors
    always @(negedge clk) begin
        if (rv0) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0_tid", LW'(rt0), LW'(e.tid));
                check("u0_data", rd0, e.data);
                check("u0_err", LW'(re0), LW'(e.err));
                check("u0_latency", LW'(cyc), LW'(e.cyc));
            end
        end
        if (rv1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("u1_tid", LW'(rt1), LW'(e.tid));
                check("u1_data", rd1, e.data);
                check("u1_latency", LW'(cyc), LW'(e.cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] pat;
        int            n_acc;
        logic          saw_stall;

        @(negedge clk);
        @(negedge clk);
        check("rst_resp_val", LW'(rv0), 0);
        check("rst_cnt", LW'(cnt0), 0);
        check("rst_dup", LW'(dup0), 0);
        check("rst_rdy", LW'(rdy0), 1);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            pat = {16{32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000}};
            step0(1'b0, '0, '0, 1'b1, 8'(i), pat);
        end

        // Line 3 = A5 pattern, request tid 5 at byte address 0xC0
        pat = {64{8'hA5}};
        step0(1'b0, '0, '0, 1'b1, 8'd3, pat);
        step0(1'b1, 6'd5, 40'hC0, 1'b0, '0, '0);
        idle(LAT + 2);

        // Back-to-back ids 0..7 with ready held high
        for (int i = 0; i < 8; i++) begin
            check("b2b_rdy", LW'(rdy0), 1);
            step0(1'b1, 6'(i), 40'(($urandom_range(0, 255) << 6) | $urandom_range(0, 63)),
                  1'b0, '0, '0);
        end
        check("b2b_cnt_steady", LW'(cnt0), LW'(LAT));
        idle(LAT + 2);
        check("drain_cnt", LW'(cnt0), 0);

        // Preload and read same line in the same cycle, then read again
        pat = {64{8'h11}};
        step0(1'b1, 6'd20, 40'h80, 1'b1, 8'd2, pat);
        step0(1'b1, 6'd21, 40'h80, 1'b0, '0, '0);
        idle(LAT + 2);

        // Duplicate id while the first is still in flight
        step0(1'b1, 6'd9, 40'h100, 1'b0, '0, '0);
        check("dup_before", LW'(dup0), 0);
        step0(1'b1, 6'd9, 40'h140, 1'b0, '0, '0);
        check("dup_set", LW'(dup0), 1);
        idle(LAT + 2);
        check("dup_sticky", LW'(dup0), 1);

        // Upper address bits: error response or index aliasing depending on build
        step0(1'b1, 6'd33, 40'h1 << 30, 1'b0, '0, '0);
        step0(1'b1, 6'd34, (40'h1 << 30) | 40'h1C0, 1'b0, '0, '0);
        idle(LAT + 2);

        // Shallow instance: ready drops at the fill limit, all six answered in order
        n_acc = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 40 && n_acc < 6; c++) begin
            v1 = 1'b1; tid1 = 6'(n_acc); addr1 = 40'(n_acc) << 6;
            if (rdy1) begin
                q1.push_back(exp_of(6'(n_acc), 40'(n_acc) << 6));
                n_acc++;
            end else begin
                saw_stall = 1'b1;
                check("full_cnt", LW'(cnt1), 4);
            end
            @(negedge clk);
        end
        v1 = 1'b0;
        check("full_stall_seen", LW'(saw_stall), 1);
        check("full_all_accepted", LW'(n_acc), 6);
        idle(LAT + 2);
        check("full_drain_cnt", LW'(cnt1), 0);

        // Reset with three requests in flight drops them
        step0(1'b1, 6'd40, 40'h40, 1'b0, '0, '0);
        step0(1'b1, 6'd41, 40'h80, 1'b0, '0, '0);
        step0(1'b1, 6'd42, 40'hC0, 1'b0, '0, '0);
        check("pre_rst_cnt", LW'(cnt0), 3);
        do_reset();
        check("post_rst_cnt", LW'(cnt0), 0);
        check("post_rst_rdy", LW'(rdy0), 1);
        check("post_rst_val", LW'(rv0), 0);
        check("post_rst_dup", LW'(dup0), 0);
        idle(LAT + 3);

        // Id reuse after reset is served normally
        step0(1'b1, 6'd40, 40'h40, 1'b0, '0, '0);
        idle(LAT + 2);
        check("reuse_no_dup", LW'(dup0), 0);

        check("q0_empty", LW'(q0.size()), 0);
        check("q1_empty", LW'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
